reg_readback: RTL

//  Sequential read-out engine for the processor's register bank.
//  On START it reads registers 0..NUM_REGS-1 in order. The reads go through a combinational read port.

---
 rtl/reg_readback.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reg_readback.sv
// Sequential register-bank dump engine: walks addresses 0..NUM_REGS-1 through a
// combinational read port and streams each (address, word) on a valid/ready output.
module reg_readback #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  START,
  input  logic                  ABORT,
  output logic [ADDR_WIDTH-1:0] RD_ADDR,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [ADDR_WIDTH-1:0] OUT_ADDR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY,
  output logic                  DONE
);

  // state  | meaning
  // IDLE   | waiting for START
  // READ   | RD_ADDR=counter, capture RD_DATA into the output register
  // SEND   | word presented, waiting for OUT_READY
  // FINISH | one-cycle DONE pulse, then back to IDLE
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_SEND   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic                    r_out_valid;
  logic                    w_load;
  logic                    w_clr_valid;
  logic                    w_hs;

  assign w_hs = r_out_valid & OUT_READY;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_clr_valid = 1'b0;
    // ABORT outranks START and a same-cycle handshake
    if (ABORT) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_clr_valid = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            w_state_nxt = S_READ;
            w_cnt_nxt   = '0;
          end
        end
        S_READ: begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            w_clr_valid = 1'b1;
            if (r_cnt == LAST_ADDR) begin
              w_state_nxt = S_FINISH;
            end else begin
              w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
              w_state_nxt = S_READ;
            end
          end
        end
        S_FINISH: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= RD_DATA;
      r_out_addr  <= r_cnt;
      r_out_valid <= 1'b1;
    end else if (w_clr_valid) begin
      r_out_valid <= 1'b0;
    end
  end

  assign RD_ADDR   = r_cnt;
  assign OUT_DATA  = r_out_data;
  assign OUT_ADDR  = r_out_addr;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_FINISH);

endmodule
